// File: rtl/race_pkg.sv
// Shared encodings and widths for the drag-race sequencer and its car models.
package race_pkg;

    typedef enum logic [1:0] {
        ST_MENU      = 2'b00,
        ST_COUNTDOWN = 2'b01,
        ST_RACE      = 2'b10,
        ST_RESULT    = 2'b11
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int XPOS_W = 11;
    localparam int TIME_W = 16;

    // Race clock sticks at all-ones instead of wrapping.
    function automatic logic [TIME_W-1:0] sat_inc_time(input logic [TIME_W-1:0] v);
        if (v == {TIME_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(TIME_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/race_controller_car_motion.sv
// Velocity/position model of one car; finished flags the move step that reaches the line.
module car_motion
    import race_pkg::*;
#(
    parameter int X_START  = 256,
    parameter int X_FINISH = 900,
    parameter int VMAX     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic              move_step,
    input  logic              key,
    output logic [XPOS_W-1:0] xpos,
    output logic              finished
);

    localparam int VEL_W = $clog2(VMAX + 1);

    logic [VEL_W-1:0]  vel_r;
    logic [VEL_W-1:0]  vel_s;
    logic [XPOS_W-1:0] pos_r;
    logic [XPOS_W-1:0] pos_s;
    logic [XPOS_W:0]   sum_s;
    logic [VEL_W:0]    vel_sum_s;
    logic              dec_s;
    logic              reach_s;

    // Next velocity and position; the sum is one bit wider so it cannot wrap before the clamp.
    always_comb begin
        sum_s     = {1'b0, pos_r} + {{(XPOS_W + 1 - VEL_W){1'b0}}, vel_r};
        dec_s     = move_step && (vel_r != {VEL_W{1'b0}});
        vel_sum_s = {1'b0, vel_r} - {{VEL_W{1'b0}}, dec_s} + {{VEL_W{1'b0}}, key};
        reach_s   = sum_s >= (XPOS_W + 1)'(X_FINISH);
        if (vel_sum_s > (VEL_W + 1)'(VMAX)) begin
            vel_s = VEL_W'(VMAX);
        end else begin
            vel_s = vel_sum_s[VEL_W-1:0];
        end
        if (move_step && reach_s) begin
            pos_s = XPOS_W'(X_FINISH);
        end else if (move_step) begin
            pos_s = sum_s[XPOS_W-1:0];
        end else begin
            pos_s = pos_r;
        end
        finished = enable && move_step && reach_s;
    end

    // Car state registers; clear returns the car to the start line at rest.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pos_r <= XPOS_W'(X_START);
            vel_r <= {VEL_W{1'b0}};
        end else if (enable) begin
            pos_r <= pos_s;
            vel_r <= vel_s;
        end else begin
            pos_r <= pos_r;
            vel_r <= vel_r;
        end
    end

    assign xpos = pos_r;

endmodule

// File: rtl/race_controller.sv
// Game sequencer: menu, light countdown, race and result hold, driving car positions and lights.
module race_controller
    import race_pkg::*;
#(
    parameter int LIGHT_PERIOD_MS = 1000,
    parameter int NUM_LIGHTS      = 3,
    parameter int X_START         = 256,
    parameter int X_FINISH        = 900,
    parameter int VMAX            = 15,
    parameter int MOVE_PERIOD_MS  = 20,
    parameter int FINISH_HOLD_MS  = 3000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_ms,
    input  logic                  start_game,
    input  logic                  back_to_menu,
    input  logic                  p1_key,
    input  logic                  p2_key,
    output logic [1:0]            state,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  race_active,
    output logic [XPOS_W-1:0]     p1_xpos,
    output logic [XPOS_W-1:0]     p2_xpos,
    output logic [TIME_W-1:0]     race_time_ms,
    output logic [1:0]            winner,
    output logic                  false_start
);

    localparam int CNT_MAX = (LIGHT_PERIOD_MS > FINISH_HOLD_MS) ? LIGHT_PERIOD_MS : FINISH_HOLD_MS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STG_W   = $clog2(NUM_LIGHTS + 1);
    localparam int MC_W    = $clog2(MOVE_PERIOD_MS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] LIGHT_LAST = CNT_W'(LIGHT_PERIOD_MS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(FINISH_HOLD_MS - 1);
    localparam logic [STG_W-1:0] STG_ONE    = STG_W'(1'b1);
    localparam logic [STG_W-1:0] STG_LAST   = STG_W'(NUM_LIGHTS - 1);
    localparam logic [MC_W-1:0]  MC_ONE     = MC_W'(1'b1);
    localparam logic [MC_W-1:0]  MOVE_LAST  = MC_W'(MOVE_PERIOD_MS - 1);
    localparam logic [NUM_LIGHTS-1:0] LIGHT_FIRST = NUM_LIGHTS'(1'b1);

    state_t                  state_r, state_s;
    logic [NUM_LIGHTS-1:0]   lights_r, lights_s;
    logic                    race_active_r, race_active_s;
    logic [TIME_W-1:0]       time_r, time_s;
    logic [1:0]              winner_r, winner_s;
    logic                    false_start_r, false_start_s;
    logic [CNT_W-1:0]        ms_cnt_r, ms_cnt_s;
    logic [STG_W-1:0]        stage_r, stage_s;
    logic [MC_W-1:0]         move_cnt_r, move_cnt_s;
    logic                    clear_s;
    logic                    enable_s;
    logic                    move_step_s;
    logic                    p1_fin_s;
    logic                    p2_fin_s;

    // Car enables are decoded apart from the FSM so the finish flags never loop back into them.
    always_comb begin
        enable_s    = (state_r == ST_RACE) && !back_to_menu;
        move_step_s = enable_s && tick_ms && (move_cnt_r == MOVE_LAST);
    end

    car_motion #(.X_START(X_START), .X_FINISH(X_FINISH), .VMAX(VMAX)) u_car_p1 (
        .clk(clk), .rst(rst), .clear(clear_s), .enable(enable_s),
        .move_step(move_step_s), .key(p1_key), .xpos(p1_xpos), .finished(p1_fin_s)
    );

    car_motion #(.X_START(X_START), .X_FINISH(X_FINISH), .VMAX(VMAX)) u_car_p2 (
        .clk(clk), .rst(rst), .clear(clear_s), .enable(enable_s),
        .move_step(move_step_s), .key(p2_key), .xpos(p2_xpos), .finished(p2_fin_s)
    );

    // Next-state and next-output decode; back_to_menu overrides everything.
    always_comb begin
        state_s       = state_r;
        lights_s      = lights_r;
        time_s        = time_r;
        winner_s      = winner_r;
        false_start_s = false_start_r;
        ms_cnt_s      = ms_cnt_r;
        stage_s       = stage_r;
        move_cnt_s    = move_cnt_r;
        clear_s       = 1'b0;
        if (back_to_menu) begin
            state_s       = ST_MENU;
            lights_s      = {NUM_LIGHTS{1'b0}};
            time_s        = {TIME_W{1'b0}};
            winner_s      = WIN_NONE;
            false_start_s = 1'b0;
            ms_cnt_s      = {CNT_W{1'b0}};
            stage_s       = {STG_W{1'b0}};
            move_cnt_s    = {MC_W{1'b0}};
            clear_s       = 1'b1;
        end else begin
            case (state_r)
                ST_MENU: begin
                    if (start_game) begin
                        state_s       = ST_COUNTDOWN;
                        lights_s      = LIGHT_FIRST;
                        stage_s       = {STG_W{1'b0}};
                        ms_cnt_s      = {CNT_W{1'b0}};
                        time_s        = {TIME_W{1'b0}};
                        winner_s      = WIN_NONE;
                        false_start_s = 1'b0;
                        clear_s       = 1'b1;
                    end else begin
                        state_s = ST_MENU;
                    end
                end
                ST_COUNTDOWN: begin
                    // A jumper loses: the other player is credited, both jumping is a draw.
                    if (p1_key || p2_key) begin
                        state_s       = ST_RESULT;
                        false_start_s = 1'b1;
                        winner_s      = {p1_key, p2_key};
                        ms_cnt_s      = {CNT_W{1'b0}};
                    end else if (tick_ms && (ms_cnt_r == LIGHT_LAST)) begin
                        ms_cnt_s = {CNT_W{1'b0}};
                        if (stage_r == STG_LAST) begin
                            state_s    = ST_RACE;
                            lights_s   = {NUM_LIGHTS{1'b0}};
                            move_cnt_s = {MC_W{1'b0}};
                            time_s     = {TIME_W{1'b0}};
                        end else begin
                            stage_s  = stage_r + STG_ONE;
                            lights_s = (lights_r << 1'b1) | LIGHT_FIRST;
                        end
                    end else if (tick_ms) begin
                        ms_cnt_s = ms_cnt_r + CNT_ONE;
                    end else begin
                        ms_cnt_s = ms_cnt_r;
                    end
                end
                ST_RACE: begin
                    if (tick_ms) begin
                        time_s = sat_inc_time(time_r);
                        if (move_cnt_r == MOVE_LAST) begin
                            move_cnt_s = {MC_W{1'b0}};
                        end else begin
                            move_cnt_s = move_cnt_r + MC_ONE;
                        end
                    end else begin
                        time_s = time_r;
                    end
                    // Finish flags map directly onto the winner code (bit0 P1, bit1 P2).
                    if (p1_fin_s || p2_fin_s) begin
                        state_s  = ST_RESULT;
                        winner_s = {p2_fin_s, p1_fin_s};
                        ms_cnt_s = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_RACE;
                    end
                end
                ST_RESULT: begin
                    if (tick_ms && (ms_cnt_r == HOLD_LAST)) begin
                        state_s       = ST_MENU;
                        lights_s      = {NUM_LIGHTS{1'b0}};
                        time_s        = {TIME_W{1'b0}};
                        winner_s      = WIN_NONE;
                        false_start_s = 1'b0;
                        ms_cnt_s      = {CNT_W{1'b0}};
                        stage_s       = {STG_W{1'b0}};
                        clear_s       = 1'b1;
                    end else if (tick_ms) begin
                        ms_cnt_s = ms_cnt_r + CNT_ONE;
                    end else begin
                        ms_cnt_s = ms_cnt_r;
                    end
                end
                default: begin
                    state_s = ST_MENU;
                    clear_s = 1'b1;
                end
            endcase
        end
        race_active_s = (state_s == ST_RACE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_MENU;
            lights_r      <= {NUM_LIGHTS{1'b0}};
            race_active_r <= 1'b0;
            time_r        <= {TIME_W{1'b0}};
            winner_r      <= WIN_NONE;
            false_start_r <= 1'b0;
            ms_cnt_r      <= {CNT_W{1'b0}};
            stage_r       <= {STG_W{1'b0}};
            move_cnt_r    <= {MC_W{1'b0}};
        end else begin
            state_r       <= state_s;
            lights_r      <= lights_s;
            race_active_r <= race_active_s;
            time_r        <= time_s;
            winner_r      <= winner_s;
            false_start_r <= false_start_s;
            ms_cnt_r      <= ms_cnt_s;
            stage_r       <= stage_s;
            move_cnt_r    <= move_cnt_s;
        end
    end

    assign state        = state_r;
    assign lights       = lights_r;
    assign race_active  = race_active_r;
    assign race_time_ms = time_r;
    assign winner       = winner_r;
    assign false_start  = false_start_r;

endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller with short periods and a near finish line.
module tb_race_controller;

    logic        clk;
    logic        rst;
    logic        tick_ms;
    logic        start_game;
    logic        back_to_menu;
    logic        p1_key;
    logic        p2_key;
    logic [1:0]  state;
    logic [2:0]  lights;
    logic        race_active;
    logic [10:0] p1_xpos;
    logic [10:0] p2_xpos;
    logic [15:0] race_time_ms;
    logic [1:0]  winner;
    logic        false_start;
    logic [8:0]  obs;

    int total;
    int bad;

    race_controller #(
        .LIGHT_PERIOD_MS(4), .NUM_LIGHTS(3), .X_START(256), .X_FINISH(272),
        .VMAX(15), .MOVE_PERIOD_MS(2), .FINISH_HOLD_MS(5)
    ) dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .start_game(start_game),
        .back_to_menu(back_to_menu), .p1_key(p1_key), .p2_key(p2_key),
        .state(state), .lights(lights), .race_active(race_active),
        .p1_xpos(p1_xpos), .p2_xpos(p2_xpos), .race_time_ms(race_time_ms),
        .winner(winner), .false_start(false_start)
    );

    // {state, lights, race_active, winner, false_start}
    assign obs = {state, lights, race_active, winner, false_start};

    always #5 clk = ~clk;

    task automatic step(input logic t, input logic k1, input logic k2, input logic s, input logic b);
        tick_ms = t; p1_key = k1; p2_key = k2; start_game = s; back_to_menu = b;
        @(posedge clk);
        #1;
        tick_ms = 1'b0; p1_key = 1'b0; p2_key = 1'b0; start_game = 1'b0; back_to_menu = 1'b0;
    endtask

    task automatic ticks(input int n, input logic k1, input logic k2);
        for (int i = 0; i < n; i++) step(1'b1, k1, k2, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        total++; if (obs !== 9'b00_000_0_00_0) begin bad++; $display("FAIL reset_obs got=%b exp=%b", obs, 9'b00_000_0_00_0); end
        total++; if ({p1_xpos, p2_xpos} !== {11'd256, 11'd256}) begin bad++; $display("FAIL reset_xpos got=%0d/%0d exp=256/256", p1_xpos, p2_xpos); end
        total++; if (race_time_ms !== 16'd0) begin bad++; $display("FAIL reset_time got=%0d exp=0", race_time_ms); end
    endtask

    task automatic test_menu_ignore;
        ticks(3, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        total++; if (obs !== 9'b00_000_0_00_0) begin bad++; $display("FAIL menu_ignore got=%b exp=%b", obs, 9'b00_000_0_00_0); end
    endtask

    task automatic test_countdown;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (obs !== 9'b01_001_0_00_0) begin bad++; $display("FAIL cd_start got=%b exp=%b", obs, 9'b01_001_0_00_0); end
        ticks(3, 1'b0, 1'b0);
        total++; if (lights !== 3'b001) begin bad++; $display("FAIL cd_tick3 got=%b exp=001", lights); end
        ticks(1, 1'b0, 1'b0);
        total++; if (lights !== 3'b011) begin bad++; $display("FAIL cd_tick4 got=%b exp=011", lights); end
        ticks(4, 1'b0, 1'b0);
        total++; if (lights !== 3'b111) begin bad++; $display("FAIL cd_tick8 got=%b exp=111", lights); end
        ticks(3, 1'b0, 1'b0);
        total++; if (obs !== 9'b01_111_0_00_0) begin bad++; $display("FAIL cd_tick11 got=%b exp=%b", obs, 9'b01_111_0_00_0); end
        ticks(1, 1'b0, 1'b0);
        total++; if (obs !== 9'b10_000_1_00_0) begin bad++; $display("FAIL cd_race got=%b exp=%b", obs, 9'b10_000_1_00_0); end
    endtask

    task automatic test_decay;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2, 1'b0, 1'b0);
        total++; if (p1_xpos !== 11'd260) begin bad++; $display("FAIL decay_1 got=%0d exp=260", p1_xpos); end
        ticks(2, 1'b0, 1'b0);
        total++; if (p1_xpos !== 11'd263) begin bad++; $display("FAIL decay_2 got=%0d exp=263", p1_xpos); end
        ticks(2, 1'b0, 1'b0);
        total++; if (p1_xpos !== 11'd265) begin bad++; $display("FAIL decay_3 got=%0d exp=265", p1_xpos); end
        ticks(2, 1'b0, 1'b0);
        total++; if (p1_xpos !== 11'd266) begin bad++; $display("FAIL decay_4 got=%0d exp=266", p1_xpos); end
        ticks(2, 1'b0, 1'b0);
        total++; if ({p1_xpos, p2_xpos} !== {11'd266, 11'd256}) begin bad++; $display("FAIL decay_stop got=%0d/%0d exp=266/256", p1_xpos, p2_xpos); end
        total++; if (race_time_ms !== 16'd10) begin bad++; $display("FAIL decay_time got=%0d exp=10", race_time_ms); end
    endtask

    task automatic test_back_mid_race;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        total++; if (obs !== 9'b00_000_0_00_0) begin bad++; $display("FAIL back_obs got=%b exp=%b", obs, 9'b00_000_0_00_0); end
        total++; if ({p1_xpos, p2_xpos, race_time_ms} !== {11'd256, 11'd256, 16'd0}) begin bad++; $display("FAIL back_pos got=%0d/%0d t=%0d exp=256/256 t=0", p1_xpos, p2_xpos, race_time_ms); end
    endtask

    task automatic test_false_start;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (obs !== 9'b11_011_0_01_1) begin bad++; $display("FAIL fs_p2 got=%b exp=%b", obs, 9'b11_011_0_01_1); end
        total++; if ({p1_xpos, p2_xpos} !== {11'd256, 11'd256}) begin bad++; $display("FAIL fs_pos got=%0d/%0d exp=256/256", p1_xpos, p2_xpos); end
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        ticks(3, 1'b0, 1'b0);
        total++; if (obs !== 9'b11_011_0_01_1) begin bad++; $display("FAIL fs_hold got=%b exp=%b", obs, 9'b11_011_0_01_1); end
        ticks(1, 1'b0, 1'b0);
        total++; if (obs !== 9'b11_011_0_01_1) begin bad++; $display("FAIL fs_hold4 got=%b exp=%b", obs, 9'b11_011_0_01_1); end
        ticks(1, 1'b0, 1'b0);
        total++; if (obs !== 9'b00_000_0_00_0) begin bad++; $display("FAIL fs_expire got=%b exp=%b", obs, 9'b00_000_0_00_0); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        total++; if ({state, winner, false_start} !== 5'b11_11_1) begin bad++; $display("FAIL fs_both got=%b exp=11111", {state, winner, false_start}); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total++; if ({state, winner, false_start} !== 5'b11_10_1) begin bad++; $display("FAIL fs_p1 got=%b exp=11101", {state, winner, false_start}); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_race_win;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(12, 1'b0, 1'b0);
        ticks(11, 1'b1, 1'b0);
        total++; if ({state, p1_xpos} !== {2'b10, 11'd271}) begin bad++; $display("FAIL win_pre st=%b x=%0d exp=10/271", state, p1_xpos); end
        ticks(1, 1'b1, 1'b0);
        total++; if (obs !== 9'b11_000_0_01_0) begin bad++; $display("FAIL win_obs got=%b exp=%b", obs, 9'b11_000_0_01_0); end
        total++; if ({p1_xpos, p2_xpos, race_time_ms} !== {11'd272, 11'd256, 16'd12}) begin bad++; $display("FAIL win_pos got=%0d/%0d t=%0d exp=272/256 t=12", p1_xpos, p2_xpos, race_time_ms); end
        ticks(4, 1'b1, 1'b1);
        total++; if ({state, p1_xpos, race_time_ms} !== {2'b11, 11'd272, 16'd12}) begin bad++; $display("FAIL win_hold st=%b x=%0d t=%0d exp=11/272/12", state, p1_xpos, race_time_ms); end
        ticks(1, 1'b0, 1'b0);
        total++; if (obs !== 9'b00_000_0_00_0) begin bad++; $display("FAIL win_expire got=%b exp=%b", obs, 9'b00_000_0_00_0); end
        total++; if ({p1_xpos, p2_xpos, race_time_ms} !== {11'd256, 11'd256, 16'd0}) begin bad++; $display("FAIL win_clear got=%0d/%0d t=%0d exp=256/256 t=0", p1_xpos, p2_xpos, race_time_ms); end
    endtask

    task automatic test_draw;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(12, 1'b0, 1'b0);
        ticks(12, 1'b1, 1'b1);
        total++; if ({state, winner} !== 4'b11_11) begin bad++; $display("FAIL draw_win got=%b exp=1111", {state, winner}); end
        total++; if ({p1_xpos, p2_xpos} !== {11'd272, 11'd272}) begin bad++; $display("FAIL draw_pos got=%0d/%0d exp=272/272", p1_xpos, p2_xpos); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_rst_mid_countdown;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(5, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        total++; if (obs !== 9'b00_000_0_00_0) begin bad++; $display("FAIL rst_cd got=%b exp=%b", obs, 9'b00_000_0_00_0); end
        total++; if ({p1_xpos, race_time_ms} !== {11'd256, 16'd0}) begin bad++; $display("FAIL rst_cd_pos got=%0d t=%0d exp=256 t=0", p1_xpos, race_time_ms); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(4, 1'b0, 1'b0);
        total++; if ({state, lights} !== 5'b01_011) begin bad++; $display("FAIL rst_restart got=%b exp=01011", {state, lights}); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; tick_ms = 1'b0; start_game = 1'b0;
        back_to_menu = 1'b0; p1_key = 1'b0; p2_key = 1'b0;
        total = 0; bad = 0;
        test_reset();
        test_menu_ignore();
        test_countdown();
        test_decay();
        test_back_mid_race();
        test_false_start();
        test_race_win();
        test_draw();
        test_rst_mid_countdown();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
